// File: rtl/wb_master_interface_if.sv
// Wishbone B4 pipelined bus bundle seen from the initiator side.
// Signal suffixes follow the initiator's point of view (_o driven by the master).
interface wb_master_interface_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stall_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_stall_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_stall_i
  );
endinterface

// File: rtl/wb_master_interface.sv
// Single-outstanding pipelined Wishbone B4 initiator: accepts one request over
// valid/ready, runs one bus cycle, and returns a one-cycle response (data or timeout).
module wb_master_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_addr_i,
  input  logic                   req_we_i,
  input  logic [3:0]             req_sel_i,
  input  logic [31:0]            req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  wb_master_interface_if.master  wb
);

  // A disabled timeout still needs a one-bit counter to keep the datapath legal.
  localparam int unsigned     CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_ACK,
    ST_RESPONSE
  } state_e;

  state_e           r_state,  w_state_next;
  logic [31:0]      r_adr,    w_adr_next;
  logic [31:0]      r_dat,    w_dat_next;
  logic             r_we,     w_we_next;
  logic [3:0]       r_sel,    w_sel_next;
  logic             r_cyc,    w_cyc_next;
  logic             r_stb,    w_stb_next;
  logic             r_rsp_valid, w_rsp_valid_next;
  logic             r_rsp_err,   w_rsp_err_next;
  logic [31:0]      r_rsp_rdata, w_rsp_rdata_next;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_ack_taken;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_LIMIT);

  // An ack only counts once the strobe has actually been taken by the slave.
  assign w_ack_taken = wb.wb_ack_i &&
                       ((r_state == ST_WAIT_ACK) ||
                        (r_state == ST_REQUEST && !wb.wb_stall_i));

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_adr_next       = r_adr;
    w_dat_next       = r_dat;
    w_we_next        = r_we;
    w_sel_next       = r_sel;
    w_cyc_next       = r_cyc;
    w_stb_next       = r_stb;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_rdata_next = r_rsp_rdata;
    w_cnt_next       = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          w_adr_next   = req_addr_i;
          w_dat_next   = req_wdata_i;
          w_we_next    = req_we_i;
          w_sel_next   = req_sel_i;
          w_cyc_next   = 1'b1;
          w_stb_next   = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_REQUEST;
        end
      end

      ST_REQUEST, ST_WAIT_ACK: begin
        if (w_ack_taken) begin
          w_cyc_next       = 1'b0;
          w_stb_next       = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b0;
          w_rsp_rdata_next = r_we ? 32'd0 : wb.wb_dat_i;
          w_state_next     = ST_RESPONSE;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (r_state == ST_REQUEST && !wb.wb_stall_i) begin
            w_stb_next   = 1'b0;
            w_state_next = ST_WAIT_ACK;
          end
          if (w_timeout) begin
            w_cyc_next       = 1'b0;
            w_stb_next       = 1'b0;
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
            w_rsp_rdata_next = 32'd0;
            w_state_next     = ST_RESPONSE;
          end
        end
      end

      ST_RESPONSE: begin
        w_rsp_valid_next = 1'b0;
        w_rsp_err_next   = 1'b0;
        w_rsp_rdata_next = 32'd0;
        w_state_next     = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: all bus and response registers are reset so the bus is quiet and
  // deterministic the instant rst_ni falls, even mid-transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_adr       <= '0;
      r_dat       <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_adr       <= w_adr_next;
      r_dat       <= w_dat_next;
      r_we        <= w_we_next;
      r_sel       <= w_sel_next;
      r_cyc       <= w_cyc_next;
      r_stb       <= w_stb_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;

  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_sel_o = r_sel;
  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_stb;

endmodule

// File: tb/tb_wb_master_interface.sv
// Self-checking bench for wb_master_interface: scripted slave behaviour per scenario,
// expected responses queued at issue time and compared whenever rsp_valid_o fires.
module tb_wb_master_interface;

  localparam int unsigned TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_sel_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  wb_master_interface_if wb ();

  wb_master_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_sel_i   (req_sel_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .wb          (wb)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_exp;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   rsp_count = 0;
  int   exp_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
    exp_count++;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                       input logic [31:0] wdata);
    int budget;
    budget      = 0;
    req_addr_i  = addr;
    req_we_i    = we;
    req_sel_i   = sel;
    req_wdata_i = wdata;
    req_i       = 1'b1;
    while (!req_ready_o && budget < 20) begin
      @(negedge clk_i);
      budget++;
    end
    check("accept_in_time", 32'(budget < 20), 32'd1);
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  // Response scoreboard.
  always @(negedge clk_i) begin
    if (rsp_valid_o) begin
      rsp_count++;
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("rsp_rdata", rsp_rdata_o, mon_exp.rdata);
        check("rsp_err", 32'(rsp_err_o), 32'(mon_exp.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int cyc_cnt;
  int start0, start1, first_rsp;
  logic prev_stb;

  initial begin
    req_i         = 1'b0;
    req_addr_i    = '0;
    req_we_i      = 1'b0;
    req_sel_i     = '0;
    req_wdata_i   = '0;
    wb.wb_dat_i   = '0;
    wb.wb_ack_i   = 1'b0;
    wb.wb_stall_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_cyc",   32'(wb.wb_cyc_o), 32'd0);
    check("rst_stb",   32'(wb.wb_stb_o), 32'd0);
    check("rst_we",    32'(wb.wb_we_o),  32'd0);
    check("rst_adr",   wb.wb_adr_o,      32'd0);
    check("rst_dat",   wb.wb_dat_o,      32'd0);
    check("rst_sel",   32'(wb.wb_sel_o), 32'd0);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_err",   32'(rsp_err_o),   32'd0);
    check("rst_rdata", rsp_rdata_o,      32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Zero-wait read
    expect_rsp(32'h1234_5678, 1'b0);
    issue(32'h04, 1'b0, 4'hF, 32'h0);
    check("t1_stb",   32'(wb.wb_stb_o),  32'd1);
    check("t1_cyc",   32'(wb.wb_cyc_o),  32'd1);
    check("t1_adr",   wb.wb_adr_o,       32'h04);
    check("t1_we",    32'(wb.wb_we_o),   32'd0);
    check("t1_ready", 32'(req_ready_o),  32'd0);
    @(negedge clk_i);
    check("t1_stb_1cyc", 32'(wb.wb_stb_o), 32'd0);
    check("t1_cyc_wait", 32'(wb.wb_cyc_o), 32'd1);
    wb.wb_ack_i = 1'b1;
    wb.wb_dat_i = 32'h1234_5678;
    @(negedge clk_i);
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = 32'hDEAD_BEEF;
    check("t1_cyc_done", 32'(wb.wb_cyc_o), 32'd0);
    check("t1_valid",    32'(rsp_valid_o), 32'd1);
    check("t1_ready_busy", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("t1_valid_pulse", 32'(rsp_valid_o), 32'd0);
    check("t1_rdata_clr",   rsp_rdata_o,      32'd0);
    check("t1_ready_back",  32'(req_ready_o), 32'd1);

    // Stalled write; an ack while stalled must be ignored
    expect_rsp(32'd0, 1'b0);
    wb.wb_stall_i = 1'b1;
    wb.wb_dat_i   = 32'hCAFE_F00D;
    issue(32'h0C, 1'b1, 4'h1, 32'h41);
    for (int k = 0; k < 4; k++) begin
      check("t2_stb", 32'(wb.wb_stb_o), 32'd1);
      check("t2_adr", wb.wb_adr_o,      32'h0C);
      check("t2_dat", wb.wb_dat_o,      32'h41);
      check("t2_sel", 32'(wb.wb_sel_o), 32'h1);
      check("t2_we",  32'(wb.wb_we_o),  32'd1);
      wb.wb_stall_i = (k < 3);
      wb.wb_ack_i   = (k == 1);
      @(negedge clk_i);
    end
    check("t2_stb_drop", 32'(wb.wb_stb_o), 32'd0);
    check("t2_cyc_hold", 32'(wb.wb_cyc_o), 32'd1);
    wb.wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb.wb_ack_i = 1'b0;
    check("t2_valid", 32'(rsp_valid_o), 32'd1);
    @(negedge clk_i);

    // Timeout: slave never acks
    expect_rsp(32'd0, 1'b1);
    wb.wb_dat_i = 32'h5555_AAAA;
    issue(32'h20, 1'b0, 4'hF, 32'h0);
    cyc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!wb.wb_cyc_o) break;
      cyc_cnt++;
      @(negedge clk_i);
    end
    check("t3_cyc_cycles", 32'(cyc_cnt),     32'(TO));
    check("t3_valid",      32'(rsp_valid_o), 32'd1);
    check("t3_err",        32'(rsp_err_o),   32'd1);
    check("t3_stb",        32'(wb.wb_stb_o), 32'd0);
    @(negedge clk_i);
    check("t3_ready",   32'(req_ready_o), 32'd1);
    check("t3_err_clr", 32'(rsp_err_o),   32'd0);

    // Ack on the exact timeout edge wins
    expect_rsp(32'hA5A5_0F0F, 1'b0);
    wb.wb_dat_i = 32'hA5A5_0F0F;
    issue(32'h30, 1'b0, 4'hF, 32'h0);
    repeat (TO - 1) @(negedge clk_i);
    check("t4_cyc_still", 32'(wb.wb_cyc_o), 32'd1);
    wb.wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb.wb_ack_i = 1'b0;
    check("t4_valid", 32'(rsp_valid_o), 32'd1);
    check("t4_err",   32'(rsp_err_o),   32'd0);
    @(negedge clk_i);

    // Ack together with an unstalled strobe completes directly
    expect_rsp(32'h0BAD_CAFE, 1'b0);
    wb.wb_dat_i = 32'h0BAD_CAFE;
    issue(32'h38, 1'b0, 4'h3, 32'h0);
    check("t4b_stb", 32'(wb.wb_stb_o), 32'd1);
    wb.wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb.wb_ack_i = 1'b0;
    check("t4b_cyc",   32'(wb.wb_cyc_o), 32'd0);
    check("t4b_valid", 32'(rsp_valid_o), 32'd1);
    @(negedge clk_i);

    // Reset during WAIT_ACK
    issue(32'h40, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    check("t5_pre_cyc", 32'(wb.wb_cyc_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t5_cyc_async",   32'(wb.wb_cyc_o), 32'd0);
    check("t5_stb_async",   32'(wb.wb_stb_o), 32'd0);
    check("t5_ready_async", 32'(req_ready_o), 32'd1);
    check("t5_adr_async",   wb.wb_adr_o,      32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("t5_no_rsp", 32'(rsp_count), 32'(exp_count));
    expect_rsp(32'h1357_9BDF, 1'b0);
    wb.wb_dat_i = 32'h1357_9BDF;
    issue(32'h44, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    wb.wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb.wb_ack_i = 1'b0;
    check("t5_valid", 32'(rsp_valid_o), 32'd1);
    @(negedge clk_i);

    // Back-to-back with req_i held; slave acks the cycle after stb
    expect_rsp(~32'h100, 1'b0);
    expect_rsp(~32'h200, 1'b0);
    req_addr_i  = 32'h100;
    req_we_i    = 1'b0;
    req_sel_i   = 4'hF;
    req_wdata_i = 32'h0;
    req_i       = 1'b1;
    start0 = -1; start1 = -1; first_rsp = -1; prev_stb = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (wb.wb_stb_o && !prev_stb) begin
        if (start0 < 0) begin
          start0 = c;
          check("t6_adr0", wb.wb_adr_o, 32'h100);
          req_addr_i = 32'h200;
        end else if (start1 < 0) begin
          start1 = c;
          check("t6_adr1", wb.wb_adr_o, 32'h200);
          req_i = 1'b0;
        end
      end
      if (rsp_valid_o && first_rsp < 0) first_rsp = c;
      wb.wb_ack_i = wb.wb_cyc_o && !wb.wb_stb_o;
      wb.wb_dat_i = ~wb.wb_adr_o;
      prev_stb    = wb.wb_stb_o;
      @(negedge clk_i);
    end
    wb.wb_ack_i = 1'b0;
    req_i       = 1'b0;
    check("t6_both_started", 32'(start0 >= 0 && start1 >= 0), 32'd1);
    check("t6_spacing",      32'(start1 - start0),            32'd4);
    check("t6_after_rsp",    32'(first_rsp >= 0 && start1 > first_rsp), 32'd1);

    check("sb_drained",  32'(sb.size()),  32'd0);
    check("rsp_total",   32'(rsp_count),  32'(exp_count));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
